fetch_queue: RTL and testbench

//  Instruction prefetch queue between instruction memory and the ID stage of the 5-stage CPU.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fq_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_fetch_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NOP_INST    bubble instruction presented to ID when the queue is empty
//   fq_state_t  fetch FSM encoding (IDLE / WAIT / KILL)
//   fq_entry_t  one queue entry, {pc4, inst}
//   word_align  clears the low two address bits
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          FQ_W     = 64;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_KILL = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// DEPTH x W circular buffer holding fetched {pc4, inst} entries.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller never pushes when full unless it also pops.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         synchronous flush (pointers and count to zero)
//   push        write push_dat at the tail
//   push_dat    entry to write
//   pop         advance the head
//   head_dat    entry at the head (combinational from storage)
//   count       occupied entries, 0..DEPTH
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; count alone
  // distinguishes full from empty when the pointers are equal.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !(rst || clr)) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and ID; flushes on redirect.
// Latency: response enters the queue, out_valid the cycle after ack (same cycle with bypass).
// Backpressure: hold stalls pops; fetching stops when the queue would reach DEPTH.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect, redirect_pc    taken branch/jump: flush and refetch from redirect_pc & ~3
//   hold                     ID stall, no pop while high
//   imem_req/addr/ack/rdata  single-outstanding request/ack memory interface
//   out_valid/inst/pc4       queue head (NOP_INST / 0 when empty)
//   count                    occupied entries
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response straight
// to out_* in the ack cycle when the queue is empty.
import fetch_pkg::*;

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   hold,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_t     state_q;
  fq_state_t     state_nx;
  logic [31:0]   fetch_pc_q;   // next address to request
  logic [31:0]   fetch_pc_nx;
  logic [31:0]   addr_q;       // address of the request on the bus
  logic [31:0]   addr_nx;

  logic          ack_w;
  logic          push;
  logic          pop;
  logic          byp_vld;
  logic          fifo_vld;
  logic          fifo_push;
  logic          fifo_pop;
  logic          room;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nx;
  logic [31:0]   target_pc;
  fq_entry_t     resp_ent;
  fq_entry_t     fifo_head;
  fq_entry_t     head_ent;

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  assign imem_req  = (state_q != FQ_IDLE);
  assign imem_addr = addr_q;

  // An ack outside an active request is meaningless and ignored.
  assign ack_w     = imem_ack & imem_req;
  assign push      = ack_w & (state_q == FQ_WAIT) & ~redirect;
  assign target_pc = word_align(redirect_pc);

  assign resp_ent.pc4  = addr_q + 32'd4;
  assign resp_ent.inst = imem_rdata;

  assign fifo_vld = (fifo_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: present the response directly in the ack cycle.
  assign byp_vld = push & ~fifo_vld;
`else
  assign byp_vld = 1'b0;
`endif

  assign out_valid = fifo_vld | byp_vld;
  assign head_ent  = byp_vld ? resp_ent : fifo_head;
  assign out_inst  = out_valid ? head_ent.inst : NOP_INST;
  assign out_pc4   = out_valid ? head_ent.pc4  : 32'd0;

  // Redirect beats pop: the head stays put and is then flushed.
  assign pop = out_valid & ~hold & ~redirect;

  // A bypassed response consumed by ID this cycle never touches storage;
  // a bypassed response under hold is written normally.
  assign fifo_push = push & ~(byp_vld & ~hold);
  assign fifo_pop  = pop & fifo_vld;

  assign count_nx = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign room     = (count_nx < CW'(DEPTH));
  assign count    = fifo_count;

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     (FQ_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect),
    .push     (fifo_push),
    .push_dat (resp_ent),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  // ------------------------------------------------------------------
  // Fetch FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_nx;
      fetch_pc_q <= fetch_pc_nx;
      addr_q     <= addr_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    fetch_pc_nx = fetch_pc_q;
    addr_nx     = addr_q;

    case (state_q)
      FQ_IDLE: begin
        if (redirect) begin
          // Queue is flushed; the new fetch goes out next cycle.
          fetch_pc_nx = target_pc;
        end else if (room) begin
          state_nx = FQ_WAIT;
          addr_nx  = fetch_pc_q;
        end
      end

      FQ_WAIT: begin
        if (redirect) begin
          fetch_pc_nx = target_pc;
          // If the response lands with the redirect it is simply dropped;
          // otherwise the outstanding request must be drained in KILL.
          state_nx = ack_w ? FQ_IDLE : FQ_KILL;
        end else if (ack_w) begin
          fetch_pc_nx = fetch_pc_q + 32'd4;
          if (room) begin
            addr_nx = fetch_pc_q + 32'd4;
          end else begin
            state_nx = FQ_IDLE;
          end
        end
      end

      FQ_KILL: begin
        // Request address stays put until the stale response arrives.
        if (redirect) begin
          fetch_pc_nx = target_pc;
        end
        // A stale ack ends the drain even if a newer redirect shows up with
        // it; staying in KILL would re-issue an already completed request.
        if (ack_w) begin
          state_nx = FQ_IDLE;
        end
      end

      default: begin
        state_nx = FQ_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  // memory model controls
  int lat_fixed = 0;
  int lat_rand  = 0;
  int wcnt      = 0;
  int eff_lat;
  bit rand_lat  = 1'b0;
  bit byp_word  = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .hold(hold), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc4(out_pc4), .count(count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit special);
    if (special && a == 32'd0) return 32'h2002_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Variable-latency memory: acks once the request has waited eff_lat cycles.
  assign eff_lat    = rand_lat ? lat_rand : lat_fixed;
  assign imem_ack   = imem_req && (wcnt >= eff_lat);
  assign imem_rdata = imem_req ? mem_word(imem_addr, byp_word) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (imem_req && imem_ack) lat_rand <= $urandom_range(0, 3);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; hold = 1'b0; redirect_pc = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; hold = 1'b0;
    cyc();
    smp();
    total++; if (imem_req !== 1'b0)  begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", out_inst); end
    total++; if (out_pc4 !== 32'h0)  begin bad++; $display("FAIL reset_pc4: got %h want 0", out_pc4); end
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    cyc();
    rst = 1'b0;
  endtask

  // 0-wait memory, no stall: one request and one instruction per cycle.
  task automatic test_stream();
    int ia = 0;
    int ip = 0;
    do_reset();
    lat_fixed = 0;
    for (int c = 0; c < 14; c++) begin
      smp();
      if (imem_req) begin
        total++;
        if (imem_addr !== 32'(4 * ia)) begin bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, 32'(4 * ia)); end
        ia++;
      end else if (ia > 0) begin
        total++; bad++; $display("FAIL stream_req_gap: got req=0 want 1 at request %0d", ia);
      end
      if (out_valid) begin
        total++;
        if (out_pc4 !== 32'(4 * (ip + 1)) || out_inst !== mem_word(32'(4 * ip), 1'b0)) begin
          bad++; $display("FAIL stream_out: got pc4=%h inst=%h want pc4=%h inst=%h",
                          out_pc4, out_inst, 32'(4 * (ip + 1)), mem_word(32'(4 * ip), 1'b0));
        end
        ip++;
      end else if (ip > 0) begin
        total++; bad++; $display("FAIL stream_valid_gap: got valid=0 want 1 at entry %0d", ip);
      end
      cyc();
    end
    total++; if (ip < 10) begin bad++; $display("FAIL stream_pops: got %0d want >=10", ip); end
  endtask

  // Stall ID until the queue fills, then drain and verify the sequence.
  task automatic test_hold();
    logic [31:0] exp = 32'd0;
    int pops = 0;
    int n = 0;
    do_reset();
    lat_fixed = 0;
    hold = 1'b1;
    for (int c = 0; c < 12; c++) begin
      smp();
      total++; if (count > 3'd4) begin bad++; $display("FAIL hold_count_bound: got %0d want <=4", count); end
      if (c == 11) begin
        total++; if (count !== 3'd4)    begin bad++; $display("FAIL hold_full: got %0d want 4", count); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req: got %0b want 0", imem_req); end
      end
      cyc();
    end
    hold = 1'b0;
    while (pops < 16 && n < 60) begin
      smp();
      if (out_valid) begin
        total++;
        if (out_pc4 !== exp + 32'd4 || out_inst !== mem_word(exp, 1'b0)) begin
          bad++; $display("FAIL hold_drain: got pc4=%h inst=%h want pc4=%h inst=%h",
                          out_pc4, out_inst, exp + 32'd4, mem_word(exp, 1'b0));
        end
        exp += 32'd4;
        pops++;
      end
      cyc();
      n++;
    end
    total++; if (pops < 16) begin bad++; $display("FAIL hold_drain_timeout: got %0d pops want 16", pops); end
  endtask

  // 3-wait memory, redirect while the request for 8 is outstanding.
  task automatic test_redirect_wait();
    bit found = 1'b0;
    bit got_out = 1'b0;
    logic [31:0] first_new = 32'hFFFF_FFFF;
    int n = 0;
    do_reset();
    lat_fixed = 3;
    while (!found && n < 40) begin
      smp();
      if (imem_req && imem_addr == 32'd8) found = 1'b1;
      cyc();
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL rw_req8_timeout: got none want req addr 8"); end
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    n = 0;
    while (!got_out && n < 40) begin
      smp();
      if (imem_req && imem_addr != 32'd8 && first_new == 32'hFFFF_FFFF) first_new = imem_addr;
      if (out_valid) begin
        got_out = 1'b1;
        total++;
        if (out_pc4 !== 32'h44 || out_inst !== mem_word(32'h40, 1'b0)) begin
          bad++; $display("FAIL rw_out: got pc4=%h inst=%h want pc4=44 inst=%h",
                          out_pc4, out_inst, mem_word(32'h40, 1'b0));
        end
      end
      cyc();
      n++;
    end
    total++; if (!got_out) begin bad++; $display("FAIL rw_out_timeout: got no valid want pc4=44"); end
    total++; if (first_new !== 32'h40) begin bad++; $display("FAIL rw_next_addr: got %h want 40", first_new); end
  endtask

  // Redirect to an unaligned target in the same cycle as an ack.
  task automatic test_redirect_ack();
    bit found = 1'b0;
    bit got_out = 1'b0;
    int n = 0;
    do_reset();
    lat_fixed = 0;
    while (!found && n < 20) begin
      smp();
      if (imem_req) found = 1'b1;
      cyc();
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL ra_req_timeout: got none want req"); end
    redirect = 1'b1; redirect_pc = 32'h103;
    smp();
    total++; if (!(imem_req && imem_ack)) begin bad++; $display("FAIL ra_coincide: got req=%0b ack=%0b want 1 1", imem_req, imem_ack); end
    cyc();
    redirect = 1'b0;
    smp();
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL ra_count: got %0d want 0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ra_valid: got %0b want 0", out_valid); end
    total++; if (imem_req !== 1'b0)  begin bad++; $display("FAIL ra_idle: got req=%0b want 0", imem_req); end
    cyc();
    smp();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL ra_next_addr: got req=%0b addr=%h want req=1 addr=100", imem_req, imem_addr);
    end
    n = 0;
    while (!got_out && n < 20) begin
      smp();
      if (out_valid) begin
        got_out = 1'b1;
        total++;
        if (out_pc4 !== 32'h104 || out_inst !== mem_word(32'h100, 1'b0)) begin
          bad++; $display("FAIL ra_out: got pc4=%h inst=%h want pc4=104", out_pc4, out_inst);
        end
      end
      cyc();
      n++;
    end
    total++; if (!got_out) begin bad++; $display("FAIL ra_out_timeout: got no valid want pc4=104"); end
  endtask

  // Reset while a request is pending and two entries are queued.
  task automatic test_rst_mid();
    bit found = 1'b0;
    bit got_req = 1'b0;
    int n = 0;
    do_reset();
    lat_fixed = 3;
    hold = 1'b1;
    while (!found && n < 40) begin
      smp();
      if (count == 3'd2 && imem_req && !imem_ack) found = 1'b1;
      cyc();
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL rm_setup_timeout: got count=%0d want 2", count); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %0b want 0", out_valid); end
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL rm_count: got %0d want 0", count); end
    total++; if (imem_req !== 1'b0)  begin bad++; $display("FAIL rm_req: got %0b want 0", imem_req); end
    n = 0;
    while (!got_req && n < 10) begin
      cyc();
      smp();
      if (imem_req) begin
        got_req = 1'b1;
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rm_first_addr: got %h want 0", imem_addr); end
      end
      n++;
    end
    total++; if (!got_req) begin bad++; $display("FAIL rm_req_timeout: got none want req"); end
    cyc();
    hold = 1'b0;
  endtask

  // Earliest visibility of a response into an empty queue.
  task automatic test_bypass();
    bit found = 1'b0;
    int n = 0;
    do_reset();
    byp_word = 1'b1;
    lat_fixed = 2;
    while (!found && n < 20) begin
      smp();
      if (imem_req && imem_ack) found = 1'b1;
      else cyc();
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL byp_ack_timeout: got no ack want ack"); end
`ifdef FETCH_QUEUE_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h2002_0005 || out_pc4 !== 32'h4) begin
      bad++; $display("FAIL byp_same: got v=%0b inst=%h pc4=%h want v=1 inst=20020005 pc4=4", out_valid, out_inst, out_pc4);
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_count0: got %0d want 0", count); end
    cyc();
    smp();
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL byp_next: got count=%0d v=%0b want 0 0", count, out_valid);
    end
`else
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL byp_same: got v=%0b count=%0d want 0 0", out_valid, count);
    end
    cyc();
    smp();
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h2002_0005 || out_pc4 !== 32'h4) begin
      bad++; $display("FAIL byp_next: got v=%0b inst=%h pc4=%h want v=1 inst=20020005 pc4=4", out_valid, out_inst, out_pc4);
    end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL byp_count1: got %0d want 1", count); end
`endif
    cyc();
    byp_word = 1'b0;
  endtask

  // Random stall/redirect/latency against a sequential-stream reference.
  task automatic test_random();
    logic [31:0] exp = 32'd0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic [31:0] p_addr = 32'd0;
    int pops = 0;
    do_reset();
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      hold     = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      smp();
      total++; if (count > 3'd4) begin bad++; $display("FAIL rnd_count: got %0d want <=4", count); end
      if (!out_valid) begin
        total++; if (out_inst !== 32'h0 || out_pc4 !== 32'h0) begin
          bad++; $display("FAIL rnd_bubble: got inst=%h pc4=%h want 0 0", out_inst, out_pc4);
        end
      end else if (!hold && !redirect) begin
        total++;
        if (out_pc4 !== exp + 32'd4 || out_inst !== mem_word(exp, 1'b0)) begin
          bad++; $display("FAIL rnd_stream: got pc4=%h inst=%h want pc4=%h inst=%h",
                          out_pc4, out_inst, exp + 32'd4, mem_word(exp, 1'b0));
        end
        exp += 32'd4;
        pops++;
      end
      if (p_req && !p_ack) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          bad++; $display("FAIL rnd_req_stable: got req=%0b addr=%h want 1 %h", imem_req, imem_addr, p_addr);
        end
      end
      if (redirect) exp = redirect_pc & 32'hFFFF_FFFC;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      cyc();
    end
    redirect = 1'b0; hold = 1'b0; rand_lat = 1'b0;
    total++; if (pops < 500) begin bad++; $display("FAIL rnd_progress: got %0d pops want >=500", pops); end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; hold = 1'b0;
    cyc();
    test_reset();
    test_stream();
    test_hold();
    test_redirect_wait();
    test_redirect_ack();
    test_rst_mid();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
